drum_seq_ctrl: RTL and testbench
================================

DRUM_SEQ_CTRL -- requirements
Module: drum_seq_ctrl

Interface
REQ-001 SHALL have parameter STEPS, default 16, number of pattern steps (power of two, 4..16).
REQ-002 SHALL have parameter BASE_DIV, default 250000, clock cycles per tempo unit.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port key_strobe, input, 1, key-held level from the keypad encoder.
REQ-006 SHALL have port key_code, input, 5, encoded key: 0-15 pad, 16 PLAY, 17 REC, 18 TEMPO, 19 CLEAR.
REQ-007 SHALL have port trig, output, 1, one-cycle voice trigger pulse.
REQ-008 SHALL have port trig_pad, output, 4, pad ID qualified by trig.
REQ-009 SHALL have port step, output, 4, current step index.
REQ-010 SHALL have port mode, output, 2, state: 0 STOP, 1 PLAY, 2 REC.
REQ-011 SHALL have port tempo_sel, output, 2, tempo preset index.
REQ-012 SHALL have port click, output, 1, metronome pulse (see Configuration).

Function
REQ-013 SHALL accept a key event only in the cycle after key_strobe rises 0->1, sampling key_code in that cycle; a held key yields exactly one event.
REQ-014 SHALL store a pattern of STEPS entries, each a valid bit and a 4-bit pad ID.
REQ-015 SHALL implement FSM STOP/PLAY/REC: STOP+PLAY->PLAY; STOP+REC->REC; PLAY+PLAY->STOP; PLAY+REC->REC; REC+PLAY->STOP; REC+REC->PLAY.
REQ-016 SHALL set step and period counter to 0 on STOP->PLAY or STOP->REC; PLAY<->REC keeps both.
REQ-017 SHALL hold step and counter frozen in STOP; step shows last value.
REQ-018 SHALL, in PLAY/REC, count 0..P-1 with P=(tempo_sel+1)*BASE_DIV; on P-1 the counter wraps to 0 and step increments, STEPS-1 wrapping to 0.
REQ-019 SHALL, in PLAY/REC with counter==0 and the current step valid, pulse trig for one cycle with trig_pad = stored pad ID.
REQ-020 SHALL, on a pad event in any state, pulse trig the next cycle with trig_pad = key_code[3:0] (audition).
REQ-021 SHALL, on a pad event in REC, write {valid=1, pad} into the entry at the current step index (pre-increment if boundary coincides).
REQ-022 SHALL give the audition trigger priority when it coincides with a scheduled trigger; the scheduled one is dropped.
REQ-023 SHALL increment tempo_sel on TEMPO in any state, 3 wrapping to 0; new P applies from next counter wrap.
REQ-024 SHALL clear all valid bits in one cycle on CLEAR in STOP; CLEAR is ignored in PLAY/REC.
REQ-025 SHALL ignore key_code values 20-31.

Reset
REQ-026 SHALL on rst low drive: mode STOP, step 0, counter 0, tempo_sel 0, trig 0, trig_pad 0, click 0, all valid bits 0, edge-detect history 0.
REQ-027 SHALL treat a key held across reset release as not new; it generates no event.

Configuration
REQ-028 SHALL, with DRUM_SEQ_METRONOME_EN defined, pulse click one cycle when counter==0 in PLAY/REC and step[1:0]==0.
REQ-029 SHALL, without DRUM_SEQ_METRONOME_EN, tie click to 0 and omit its logic.

Structure
REQ-030 SHALL take mode enum, key-code constants (PAD range, KEY_PLAY=16, KEY_REC=17, KEY_TEMPO=18, KEY_CLEAR=19) and default STEPS from shared package drum_seq_pkg.
REQ-031 SHALL place the period counter and step counter in sub-module seq_step_timer (inputs run, restart, tempo_sel; outputs step, step_start).

Verification (BASE_DIV=4)
REQ-032 SHALL check key 16 held 10 cycles from STOP -> one event, mode=1, step=0, advances to 1 after 4 cycles, wraps 15->0 after 64.
REQ-033 SHALL check REC, pad 5 pressed at step 3 -> entry 3 = {1,5}, trig_pad=5 pulse; next PLAY pass pulses trig/trig_pad=5 at step 3 start.
REQ-034 SHALL check pad 9 pressed so audition lands on step-3 start -> single trig with trig_pad=9.
REQ-035 SHALL check TEMPO x2 in PLAY -> tempo_sel=2, step period becomes 12 after next wrap; x4 total -> tempo_sel=0.
REQ-036 SHALL check CLEAR in PLAY ignored; in STOP -> no triggers on next PLAY pass; rst low mid-PLAY -> all REQ-026 values immediately.
REQ-037 SHALL check with DRUM_SEQ_METRONOME_EN, click pulses at steps 0,4,8,12 only; without it, click stays 0.

Source files
------------

// File: rtl/drum_seq_pkg.sv
// Shared definitions for the drum step sequencer: mode encoding, key codes
// and the default pattern length.
package drum_seq_pkg;

  typedef enum logic [1:0] {
    MODE_STOP = 2'd0,
    MODE_PLAY = 2'd1,
    MODE_REC  = 2'd2
  } mode_e;

  localparam int DEFAULT_STEPS = 16;

  localparam logic [4:0] KEY_PAD_MIN = 5'd0;
  localparam logic [4:0] KEY_PAD_MAX = 5'd15;
  localparam logic [4:0] KEY_PLAY    = 5'd16;
  localparam logic [4:0] KEY_REC     = 5'd17;
  localparam logic [4:0] KEY_TEMPO   = 5'd18;
  localparam logic [4:0] KEY_CLEAR   = 5'd19;

  function automatic logic is_pad(input logic [4:0] code);
    return (code >= KEY_PAD_MIN) && (code <= KEY_PAD_MAX);
  endfunction

endpackage

// File: rtl/seq_step_timer.sv
// Tempo period counter and step counter; the period length is latched on every
// wrap (and on restart) so a tempo change only takes effect at a step boundary.
module seq_step_timer
  import drum_seq_pkg::*;
#(
  parameter int STEPS    = DEFAULT_STEPS,
  parameter int BASE_DIV = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       restart,
  input  logic [1:0] tempo_sel,
  output logic [3:0] step,
  output logic       step_start
);

  localparam int CW = $clog2(4 * BASE_DIV);

  logic [CW-1:0] count;
  logic [CW-1:0] last;

  function automatic logic [CW-1:0] period_last(input logic [1:0] t);
    return CW'((int'(t) + 1) * BASE_DIV - 1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      step  <= '0;
      last  <= period_last(2'd0);
    end else if (restart) begin
      count <= '0;
      step  <= '0;
      last  <= period_last(tempo_sel);
    end else if (run) begin
      if (count == last) begin
        count <= '0;
        step  <= (step == 4'(STEPS - 1)) ? 4'd0 : step + 4'd1;
        last  <= period_last(tempo_sel);
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign step_start = run && (count == '0);

endmodule

// File: rtl/drum_seq_ctrl.sv
// Keypad-driven drum step sequencer with record, playback and pad audition.
// Define DRUM_SEQ_METRONOME_EN to enable the metronome click output.
module drum_seq_ctrl
  import drum_seq_pkg::*;
#(
  parameter int STEPS    = DEFAULT_STEPS,
  parameter int BASE_DIV = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_strobe,
  input  logic [4:0] key_code,
  output logic       trig,
  output logic [3:0] trig_pad,
  output logic [3:0] step,
  output logic [1:0] mode,
  output logic [1:0] tempo_sel,
  output logic       click
);

  localparam int SW = $clog2(STEPS);

  mode_e            state;
  mode_e            next_state;
  logic             key_prev;
  logic             armed;
  logic             key_ev;
  logic             pad_ev;
  logic             play_ev;
  logic             rec_ev;
  logic             tempo_ev;
  logic             clear_ev;
  logic             run;
  logic             restart;
  logic             step_start;
  logic [SW-1:0]    idx;
  logic [STEPS-1:0] valid;
  logic [3:0]       pads [STEPS];

  // armed stays low for one cycle after reset so a key already held is absorbed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_prev <= 1'b0;
      armed    <= 1'b0;
    end else begin
      key_prev <= key_strobe;
      armed    <= 1'b1;
    end
  end

  always_comb begin
    key_ev   = armed && key_strobe && !key_prev;
    pad_ev   = key_ev && is_pad(key_code);
    play_ev  = key_ev && (key_code == KEY_PLAY);
    rec_ev   = key_ev && (key_code == KEY_REC);
    tempo_ev = key_ev && (key_code == KEY_TEMPO);
    clear_ev = key_ev && (key_code == KEY_CLEAR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= MODE_STOP;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      MODE_STOP: begin
        if (play_ev) begin
          next_state = MODE_PLAY;
        end else if (rec_ev) begin
          next_state = MODE_REC;
        end
      end
      MODE_PLAY: begin
        if (play_ev) begin
          next_state = MODE_STOP;
        end else if (rec_ev) begin
          next_state = MODE_REC;
        end
      end
      MODE_REC: begin
        if (play_ev) begin
          next_state = MODE_STOP;
        end else if (rec_ev) begin
          next_state = MODE_PLAY;
        end
      end
      default: next_state = MODE_STOP;
    endcase
  end

  // Timing restarts only when leaving STOP; PLAY<->REC keeps the position
  always_comb begin
    mode    = state;
    run     = (state != MODE_STOP);
    restart = (state == MODE_STOP) && (next_state != MODE_STOP);
  end

  seq_step_timer #(
    .STEPS    (STEPS),
    .BASE_DIV (BASE_DIV)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .restart    (restart),
    .tempo_sel  (tempo_sel),
    .step       (step),
    .step_start (step_start)
  );

  assign idx = step[SW-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tempo_sel <= 2'd0;
    end else if (tempo_ev) begin
      tempo_sel <= tempo_sel + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (clear_ev && (state == MODE_STOP)) begin
      valid <= '0;
    end else if (pad_ev && (state == MODE_REC)) begin
      valid[idx] <= 1'b1;
    end
  end

  // Pad IDs are only meaningful behind a valid bit, so they carry no reset
  always_ff @(posedge clk) begin
    if (pad_ev && (state == MODE_REC)) begin
      pads[idx] <= key_code[3:0];
    end
  end

  // Audition wins over a scheduled trigger landing in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig     <= 1'b0;
      trig_pad <= 4'd0;
    end else if (pad_ev) begin
      trig     <= 1'b1;
      trig_pad <= key_code[3:0];
    end else if (step_start && valid[idx]) begin
      trig     <= 1'b1;
      trig_pad <= pads[idx];
    end else begin
      trig     <= 1'b0;
    end
  end

`ifdef DRUM_SEQ_METRONOME_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      click <= 1'b0;
    end else begin
      click <= step_start && (step[1:0] == 2'b00);
    end
  end
`else
  assign click = 1'b0;
`endif

endmodule

// File: tb/tb_drum_seq_ctrl.sv
// Scoreboard bench for drum_seq_ctrl: a behavioural model queues expected
// triggers, a monitor pops them whenever the DUT pulses trig.
`timescale 1ns/1ps
module tb_drum_seq_ctrl;

  localparam int STEPS    = 16;
  localparam int BASE_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_strobe = 1'b0;
  logic [4:0] key_code = 5'd0;
  logic       trig;
  logic [3:0] trig_pad;
  logic [3:0] step;
  logic [1:0] mode;
  logic [1:0] tempo_sel;
  logic       click;

  always #5 clk = ~clk;

  drum_seq_ctrl #(
    .STEPS    (STEPS),
    .BASE_DIV (BASE_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_strobe (key_strobe),
    .key_code   (key_code),
    .trig       (trig),
    .trig_pad   (trig_pad),
    .step       (step),
    .mode       (mode),
    .tempo_sel  (tempo_sel),
    .click      (click)
  );

  typedef struct {
    int tag;
    int pad;
  } trig_t;

  trig_t exp_q[$];
  int    compared   = 0;
  int    mismatched = 0;

  // Reference model state: mode 0 STOP / 1 PLAY / 2 REC, position in cycles
  int m_mode, m_step, m_cnt, m_per, m_tempo;
  int m_cyc = 0;
  bit m_prev, m_armed, m_click;
  bit m_valid [STEPS];
  int m_pad   [STEPS];

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_step = 0; m_cnt = 0; m_per = BASE_DIV; m_tempo = 0;
    m_prev = 0; m_armed = 0; m_click = 0;
    for (int i = 0; i < STEPS; i++) begin
      m_valid[i] = 0;
      m_pad[i]   = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_step();
    bit    ev;
    bit    start;
    int    code;
    int    nxt;
    trig_t e;
    m_cyc++;
    code    = int'(key_code);
    ev      = m_armed && key_strobe && !m_prev;
    m_prev  = key_strobe;
    m_armed = 1;
    if (code > 19) ev = 0;
    start = (m_mode != 0) && (m_cnt == 0);
    if (ev && code < 16) begin
      e.tag = m_cyc; e.pad = code; exp_q.push_back(e);
    end else if (start && m_valid[m_step]) begin
      e.tag = m_cyc; e.pad = m_pad[m_step]; exp_q.push_back(e);
    end
`ifdef DRUM_SEQ_METRONOME_EN
    m_click = start && (m_step % 4 == 0);
`else
    m_click = 0;
`endif
    if (ev && code < 16 && m_mode == 2) begin
      m_valid[m_step] = 1;
      m_pad[m_step]   = code;
    end
    if (ev && code == 19 && m_mode == 0) begin
      for (int i = 0; i < STEPS; i++) m_valid[i] = 0;
    end
    nxt = m_mode;
    if (ev && code == 16) nxt = (m_mode == 0) ? 1 : 0;
    if (ev && code == 17) nxt = (m_mode == 2) ? 1 : 2;
    if (m_mode == 0 && nxt != 0) begin
      m_cnt = 0; m_step = 0; m_per = (m_tempo + 1) * BASE_DIV;
    end else if (m_mode != 0) begin
      if (m_cnt == m_per - 1) begin
        m_cnt  = 0;
        m_step = (m_step + 1) % STEPS;
        m_per  = (m_tempo + 1) * BASE_DIV;
      end else begin
        m_cnt++;
      end
    end
    if (ev && code == 18) m_tempo = (m_tempo + 1) % 4;
    m_mode = nxt;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  // Monitor: pops the scoreboard when trig is seen, tracks architectural outputs
  always @(negedge clk) begin
    trig_t e;
    while (exp_q.size() > 0 && exp_q[0].tag < m_cyc) begin
      e = exp_q.pop_front();
      compared++;
      mismatched++;
      $display("[TB] FAIL missed_trig: got no trig, expected pad %0d at cycle %0d", e.pad, e.tag);
    end
    if (trig) begin
      if (exp_q.size() > 0 && exp_q[0].tag == m_cyc) begin
        e = exp_q.pop_front();
        checkOutput("trig_pad", int'(trig_pad), e.pad);
      end else begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_trig: got trig=1 pad %0d, expected trig=0 (cycle %0d)", trig_pad, m_cyc);
      end
    end
    checkOutput("mode", int'(mode), m_mode);
    checkOutput("step", int'(step), m_step);
    checkOutput("tempo_sel", int'(tempo_sel), m_tempo);
    checkOutput("click", int'(click), int'(m_click));
  end

  // Caller is at a falling edge; the key is held for 'hold' cycles
  task automatic applyStimulus(input int code, input int hold, input int gap);
    key_code   = 5'(code);
    key_strobe = 1'b1;
    repeat (hold) @(negedge clk);
    key_strobe = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_for(input int s, input int c, input int budget);
    int n = 0;
    while (!(m_step == s && m_cnt == c) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(m_step == s && m_cnt == c)) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL wait_position: got step %0d cnt %0d, expected step %0d cnt %0d", m_step, m_cnt, s, c);
    end
  endtask

  task automatic check_reset_values();
    checkOutput("rst_trig", int'(trig), 0);
    checkOutput("rst_trig_pad", int'(trig_pad), 0);
    checkOutput("rst_step", int'(step), 0);
    checkOutput("rst_mode", int'(mode), 0);
    checkOutput("rst_tempo_sel", int'(tempo_sel), 0);
    checkOutput("rst_click", int'(click), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int code;
    // Key held across reset release must not produce an event
    key_code   = 5'd16;
    key_strobe = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    key_strobe = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] play from stop, held key");
    applyStimulus(16, 10, 2);
    repeat (70) @(negedge clk);

    $display("[TB] record pad 5 at step 3");
    applyStimulus(17, 1, 1);
    wait_for(3, 2, 200);
    applyStimulus(5, 2, 1);
    applyStimulus(17, 1, 1);
    repeat (80) @(negedge clk);

    $display("[TB] audition coinciding with step 3 start");
    wait_for(3, 0, 200);
    applyStimulus(9, 1, 1);
    repeat (70) @(negedge clk);

    $display("[TB] tempo changes");
    applyStimulus(18, 1, 1);
    applyStimulus(18, 1, 1);
    repeat (100) @(negedge clk);
    applyStimulus(18, 1, 1);
    applyStimulus(18, 1, 1);
    repeat (40) @(negedge clk);

    $display("[TB] clear ignored in play, honoured in stop");
    applyStimulus(19, 1, 1);
    repeat (70) @(negedge clk);
    applyStimulus(16, 1, 3);
    applyStimulus(19, 1, 1);
    applyStimulus(16, 1, 1);
    repeat (70) @(negedge clk);

    $display("[TB] random key traffic");
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 9) < 6) code = $urandom_range(0, 15);
      else                          code = $urandom_range(16, 31);
      applyStimulus(code, $urandom_range(1, 4), $urandom_range(1, 6));
    end

    $display("[TB] reset during play");
    if (m_mode != 1) begin
      if (m_mode == 2) applyStimulus(17, 1, 1);
      else             applyStimulus(16, 1, 1);
    end
    applyStimulus(18, 1, 1);
    applyStimulus(7, 1, 3);
    #2 rst = 1'b0;
    #1 check_reset_values();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(16, 1, 1);
    repeat (30) @(negedge clk);

    while (exp_q.size() > 0) begin
      trig_t e;
      e = exp_q.pop_front();
      compared++;
      mismatched++;
      $display("[TB] FAIL pending_trig: got none, expected pad %0d at cycle %0d", e.pad, e.tag);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
